// File: rtl/usb_data_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// usb_data_buffer_ctrl
//
// Sequencing controller and storage for the shared USB endpoint data buffer.
// One circular byte array is shared by two paths and the direction register
// (d_mode) decides which pair of requesters owns it:
//   RX_MODE : USB RX decoder pushes, AHB side pops (rx_data)
//   TX_MODE : AHB side pushes, USB TX encoder pops (tx_packet_data)
// A direction change passes through a single SWITCH cycle that flushes the
// buffer. clear flushes without touching the mode.
//
// Handshake semantics: every strobe (store_*, get_*) is a one-cycle request
// with no ready/back-pressure. A request is accepted or refused at the edge
// that samples it. A refused push raises overflow_err and a refused pop raises
// underflow_err, each for the single cycle after that edge. Popped data is
// presented on the cycle after the edge and held until the next accepted pop
// on the same port.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   d_mode                direction select (0 = RX, 1 = TX)
//   clear                 one-cycle flush request
//   store_tx_data/tx_data AHB push strobe and byte (TX_MODE)
//   get_rx_data/rx_data   AHB pop strobe and byte (RX_MODE)
//   store_rx_packet_data/rx_packet_data  USB push strobe and byte (RX_MODE)
//   get_tx_packet_data/tx_packet_data    USB pop strobe and byte (TX_MODE)
//   buffer_occupancy      bytes stored, 0..DEPTH
//   full, empty           occupancy flags
//   overflow_err          pulse: active push dropped because full
//   underflow_err         pulse: active pop while empty
//   state                 current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module usb_data_buffer_ctrl #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          d_mode,
   input  logic          clear,
   input  logic          store_tx_data,
   input  logic [7:0]    tx_data,
   input  logic          get_rx_data,
   output logic [7:0]    rx_data,
   input  logic          store_rx_packet_data,
   input  logic [7:0]    rx_packet_data,
   input  logic          get_tx_packet_data,
   output logic [7:0]    tx_packet_data,
   output logic [AW:0]   buffer_occupancy,
   output logic          full,
   output logic          empty,
   output logic          overflow_err,
   output logic          underflow_err,
   output logic [1:0]    state
);

   localparam logic [1:0] RX_MODE = 2'd0;
   localparam logic [1:0] TX_MODE = 2'd1;
   localparam logic [1:0] SWITCH  = 2'd2;

   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   occ;

   logic [1:0]    state_q;
   logic [1:0]    state_d;

   logic          in_rx;
   logic          in_tx;
   logic          active;
   logic          push_req;
   logic          pop_req;
   logic [7:0]    push_data;
   logic          pop_ok;
   logic          push_ok;
   logic          ovf_d;
   logic          unf_d;

   assign in_rx = (state_q == RX_MODE);
   assign in_tx = (state_q == TX_MODE);

   // clear and the SWITCH cycle both suppress every strobe, so neither can
   // produce an error pulse or move the pointers.
   assign active = !clear && (in_rx || in_tx);

   // Only the strobes that belong to the current direction are seen at all;
   // wrong-direction strobes simply never become requests.
   always_comb begin
      push_req  = 1'b0;
      pop_req   = 1'b0;
      push_data = rx_packet_data;
      if (in_rx) begin
         push_req  = store_rx_packet_data;
         pop_req   = get_rx_data;
         push_data = rx_packet_data;
      end else if (in_tx) begin
         push_req  = store_tx_data;
         pop_req   = get_tx_packet_data;
         push_data = tx_data;
      end
   end

   // A pop needs stored data; there is no push-to-pop bypass. A push into a
   // full buffer still fits when the same-cycle pop frees a slot.
   assign pop_ok  = active && pop_req && !empty;
   assign push_ok = active && push_req && (!full || pop_ok);
   assign unf_d   = active && pop_req && empty;
   assign ovf_d   = active && push_req && full && !pop_ok;

   // Next-state logic. clear freezes the mode; SWITCH lasts exactly one
   // cycle and lands in whatever direction d_mode asks for at that point.
   always_comb begin
      state_d = state_q;
      if (!clear) begin
         case (state_q)
            RX_MODE: if (d_mode)  state_d = SWITCH;
            TX_MODE: if (!d_mode) state_d = SWITCH;
            SWITCH:  state_d = d_mode ? TX_MODE : RX_MODE;
            default: state_d = RX_MODE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_MODE;
      end else begin
         state_q <= state_d;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst || clear || (state_q == SWITCH)) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Error pulses: registered, so each is high for the one cycle after the
   // refusing edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         overflow_err  <= ovf_d;
         underflow_err <= unf_d;
      end
   end

   // Storage array carries no reset; its contents survive rst and clear.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Each data output only moves on an accepted pop for its own port and
   // otherwise holds (including across SWITCH, clear and underflow).
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data        <= 8'h00;
         tx_packet_data <= 8'h00;
      end else if (pop_ok) begin
         if (in_rx) rx_data        <= mem[rd_ptr];
         if (in_tx) tx_packet_data <= mem[rd_ptr];
      end
   end

   assign buffer_occupancy = occ;
   assign full             = (occ == FULL_COUNT);
   assign empty            = (occ == '0);
   assign state            = state_q;

endmodule

// File: tb/tb_usb_data_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_usb_data_buffer_ctrl
//
// Bench for usb_data_buffer_ctrl. The driver sets one cycle of inputs at a
// falling edge, runs the reference model (a byte queue plus a mode variable)
// on those inputs and pushes the expected post-edge outputs onto exp_q. The
// monitor samples the DUT #1 after each rising edge and compares against the
// oldest entry of exp_q.
// ---------------------------------------------------------------------------
module tb_usb_data_buffer_ctrl;

   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int EW    = 29;

   // ---------------- clock / reset block ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          d_mode = 1'b0;
   logic          clear = 1'b0;
   logic          store_tx_data = 1'b0;
   logic [7:0]    tx_data = 8'h00;
   logic          get_rx_data = 1'b0;
   logic [7:0]    rx_data;
   logic          store_rx_packet_data = 1'b0;
   logic [7:0]    rx_packet_data = 8'h00;
   logic          get_tx_packet_data = 1'b0;
   logic [7:0]    tx_packet_data;
   logic [AW:0]   buffer_occupancy;
   logic          full;
   logic          empty;
   logic          overflow_err;
   logic          underflow_err;
   logic [1:0]    state;

   usb_data_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .d_mode               (d_mode),
      .clear                (clear),
      .store_tx_data        (store_tx_data),
      .tx_data              (tx_data),
      .get_rx_data          (get_rx_data),
      .rx_data              (rx_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet_data       (rx_packet_data),
      .get_tx_packet_data   (get_tx_packet_data),
      .tx_packet_data       (tx_packet_data),
      .buffer_occupancy     (buffer_occupancy),
      .full                 (full),
      .empty                (empty),
      .overflow_err         (overflow_err),
      .underflow_err        (underflow_err),
      .state                (state)
   );

   // ---------------- reference model ----------------
   // Mode values follow the DUT's debug state output: 0 RX, 1 TX, 2 SWITCH.
   logic [7:0]    m_q[$];
   int            m_mode = 0;
   logic [7:0]    m_rx = 8'h00;
   logic [7:0]    m_tx = 8'h00;

   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic model_step();
      bit         push;
      bit         pop;
      bit         ovf;
      bit         unf;
      logic [7:0] din;
      logic [7:0] v;
      logic [1:0] st;
      logic [6:0] occ;
      ovf = 1'b0;
      unf = 1'b0;
      if (rst) begin
         m_q.delete();
         m_mode = 0;
         m_rx   = 8'h00;
         m_tx   = 8'h00;
      end else if (clear) begin
         m_q.delete();
      end else if (m_mode == 2) begin
         m_q.delete();
         m_mode = d_mode ? 1 : 0;
      end else begin
         push = (m_mode == 0) ? store_rx_packet_data : store_tx_data;
         pop  = (m_mode == 0) ? get_rx_data : get_tx_packet_data;
         din  = (m_mode == 0) ? rx_packet_data : tx_data;
         if (pop) begin
            if (m_q.size() > 0) begin
               v = m_q.pop_front();
               if (m_mode == 0) m_rx = v;
               else             m_tx = v;
            end else begin
               unf = 1'b1;
            end
         end
         if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(din);
            else                    ovf = 1'b1;
         end
         if ((m_mode == 0 && d_mode) || (m_mode == 1 && !d_mode)) m_mode = 2;
      end
      st  = 2'(m_mode);
      occ = 7'(m_q.size());
      exp_q.push_back({st, occ, (m_q.size() == DEPTH), (m_q.size() == 0),
                       ovf, unf, m_rx, m_tx});
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst                  = 1'b0;
      clear                = 1'b0;
      store_tx_data        = 1'b0;
      get_rx_data          = 1'b0;
      store_rx_packet_data = 1'b0;
      get_tx_packet_data   = 1'b0;
   endtask

   task automatic cycles(input int n);
      idle_inputs();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic usb_push(input logic [7:0] b);
      idle_inputs();
      store_rx_packet_data = 1'b1;
      rx_packet_data       = b;
      tick();
   endtask

   task automatic ahb_push(input logic [7:0] b);
      idle_inputs();
      store_tx_data = 1'b1;
      tx_data       = b;
      tick();
   endtask

   task automatic ahb_pop();
      idle_inputs();
      get_rx_data = 1'b1;
      tick();
   endtask

   task automatic usb_pop();
      idle_inputs();
      get_tx_packet_data = 1'b1;
      tick();
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [EW-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",            int'(state),            int'(e[28:27]));
            chk("buffer_occupancy", int'(buffer_occupancy), int'(e[26:20]));
            chk("full",             int'(full),             int'(e[19]));
            chk("empty",            int'(empty),            int'(e[18]));
            chk("overflow_err",     int'(overflow_err),     int'(e[17]));
            chk("underflow_err",    int'(underflow_err),    int'(e[16]));
            chk("rx_data",          int'(rx_data),          int'(e[15:8]));
            chk("tx_packet_data",   int'(tx_packet_data),   int'(e[7:0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int wait_cnt;
      @(negedge clk);

      // Reset
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      idle_inputs();

      // RX basic: two pushes, two pops
      usb_push(8'hA5);
      usb_push(8'h3C);
      ahb_pop();
      ahb_pop();
      cycles(1);

      // Move to TX
      d_mode = 1'b1;
      cycles(3);

      // Fill 64, one overflow, drain 64, one underflow
      for (int i = 0; i < DEPTH; i++) ahb_push(8'(i));
      ahb_push(8'hEE);
      for (int i = 0; i < DEPTH; i++) usb_pop();
      usb_pop();
      cycles(1);

      // Simultaneous push+pop when full, then when empty
      for (int i = 0; i < DEPTH; i++) ahb_push(8'(8'h80 + i));
      idle_inputs();
      store_tx_data = 1'b1; tx_data = 8'h55; get_tx_packet_data = 1'b1;
      tick();
      for (int i = 0; i < DEPTH; i++) usb_pop();
      idle_inputs();
      store_tx_data = 1'b1; tx_data = 8'h66; get_tx_packet_data = 1'b1;
      tick();
      usb_pop();

      // Back to RX, store 5 bytes, then switch with store_tx_data in SWITCH
      d_mode = 1'b0;
      cycles(2);
      for (int i = 0; i < 5; i++) usb_push(8'(8'h10 + i));
      d_mode = 1'b1;
      ahb_push(8'h21);
      ahb_push(8'h22);
      ahb_push(8'h23);
      ahb_push(8'h24);
      usb_pop();

      // clear with 10 bytes and a same-cycle push (TX mode)
      for (int i = 0; i < 10; i++) ahb_push(8'(8'h30 + i));
      idle_inputs();
      clear = 1'b1; store_tx_data = 1'b1; tx_data = 8'h99; get_tx_packet_data = 1'b1;
      tick();
      // Wrong-direction strobes in TX mode
      idle_inputs();
      store_rx_packet_data = 1'b1; get_rx_data = 1'b1;
      tick();
      ahb_push(8'h42);
      usb_pop();

      // Wrong-direction strobes in RX mode
      d_mode = 1'b0;
      cycles(2);
      idle_inputs();
      store_tx_data = 1'b1; get_tx_packet_data = 1'b1;
      tick();
      usb_push(8'h77);

      // rst mid-burst
      for (int i = 0; i < 6; i++) usb_push(8'($urandom_range(0, 255)));
      idle_inputs();
      rst = 1'b1; store_rx_packet_data = 1'b1; get_rx_data = 1'b1;
      tick();
      cycles(1);

      // Randomized traffic with push-heavy, pop-heavy and balanced phases
      for (int i = 0; i < 3000; i++) begin
         int phase;
         int p_push;
         int p_pop;
         phase = (i / 250) % 3;
         p_push = (phase == 0) ? 85 : (phase == 1) ? 20 : 50;
         p_pop  = (phase == 0) ? 20 : (phase == 1) ? 85 : 50;
         idle_inputs();
         rst   = ($urandom_range(0, 999) == 0);
         clear = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 199) == 0) d_mode = ~d_mode;
         store_tx_data        = ($urandom_range(0, 99) < p_push);
         store_rx_packet_data = ($urandom_range(0, 99) < p_push);
         get_rx_data          = ($urandom_range(0, 99) < p_pop);
         get_tx_packet_data   = ($urandom_range(0, 99) < p_pop);
         tx_data              = 8'($urandom_range(0, 255));
         rx_packet_data       = 8'($urandom_range(0, 255));
         tick();
      end
      cycles(2);

      // Drain the scoreboard with a bounded wait
      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_data_buffer_ctrl.md
# usb_data_buffer_ctrl

Sequencing controller and storage for the shared 64-byte USB endpoint data buffer. Arbitrates between two paths:
- the AHB subordinate side (store_tx_data / get_rx_data with tx_data / rx_data);
- the USB line side (RX decoder push / TX encoder pop).

It enforces the direction selected by d_mode, flushes on clear and on direction changes, and reports buffer_occupancy back to the AHB status registers.

## Interface
- DEPTH, 64, buffer entries in bytes; must be a power of two
- AW, 6, pointer width, log2(DEPTH)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- d_mode  in  1  direction select:
  - 0 = RX: USB pushes, AHB pops
  - 1 = TX: AHB pushes, USB pops
- clear  in  1  flush request; 1-cycle pulse from the AHB control register
- store_tx_data  in  1  AHB push strobe, 1 cycle per byte
- tx_data  in  8  AHB push byte
- get_rx_data  in  1  AHB pop strobe
- rx_data  out  8  AHB pop byte
- store_rx_packet_data  in  1  USB RX push strobe
- rx_packet_data  in  8  USB RX push byte
- get_tx_packet_data  in  1  USB TX pop strobe
- tx_packet_data  out  8  USB TX pop byte
- buffer_occupancy  out  7  bytes stored, 0..DEPTH
- full  out  1  buffer_occupancy == DEPTH
- empty  out  1  buffer_occupancy == 0
- overflow_err  out  1  1-cycle pulse: accepted-direction push dropped because full
- underflow_err  out  1  1-cycle pulse: accepted-direction pop while empty

## Operation
- Storage: DEPTH x 8 circular array.
  - wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
  - Occupancy is a separate AW+1-bit counter.
- FSM states RX_MODE, TX_MODE and SWITCH; reset state is RX_MODE.
  - RX_MODE, d_mode=1 -> SWITCH.
  - TX_MODE, d_mode=0 -> SWITCH.
  - SWITCH -> TX_MODE if d_mode=1, otherwise RX_MODE (always exactly 1 cycle).
- Active requesters per state:
  - RX_MODE: push = store_rx_packet_data / rx_packet_data; pop = get_rx_data -> rx_data.
  - TX_MODE: push = store_tx_data / tx_data; pop = get_tx_packet_data -> tx_packet_data.
  - The wrong-direction strobes are ignored silently: no error and no state change.
- SWITCH:
  - Pointers and occupancy are cleared.
  - All strobes are ignored.
  - Data outputs hold their values.
- clear (any state):
  - Pointers and occupancy go to 0 on the next edge.
  - Same-cycle push and pop are discarded with no error pulses.
  - FSM state is unchanged.
  - The buffer array contents are not cleared.
- Push:
  - Writes the byte at wr_ptr and increments wr_ptr.
  - Accepted if not full, or if an active pop is accepted in the same cycle.
- Pop:
  - Reads the byte at rd_ptr and increments rd_ptr.
  - Accepted only if not empty; there is no push-to-pop bypass, so pop on empty with a simultaneous push is an underflow and the push is still accepted.
- Occupancy update:
  - +1 for push only.
  - -1 for pop only.
  - Unchanged when both are accepted.
  - Never exceeds DEPTH and never goes below 0.
- Priority, highest first: rst, clear, SWITCH, push/pop.

## Timing
- Reset values (cycle after rst sampled high):
  - rx_data = 8'h00, tx_packet_data = 8'h00.
  - buffer_occupancy = 0, empty = 1, full = 0.
  - overflow_err = 0, underflow_err = 0.
  - Pointers = 0, state = RX_MODE.
- rst asserted mid-transfer aborts the transfer; nothing is retained except the array contents.
- Pop latency is 1 cycle:
  - A pop accepted at edge N drives the data output valid after edge N and holds it until the next accepted pop on that port.
  - The AHB side samples rx_data one cycle after get_rx_data.
- Underflow: the data output holds its previous value, underflow_err is high for the one cycle after the edge, and rd_ptr is unchanged.
- Overflow: the byte is discarded, overflow_err is high for one cycle, and wr_ptr is unchanged.
- buffer_occupancy, full and empty are registered and reflect all accepted operations as of the last edge.
- Direction change costs 2 cycles: d_mode sampled at edge N causes SWITCH after N and the new mode after N+1. The first accepted request in the new direction is at edge N+2.
- Strobes may be asserted on consecutive cycles; throughput is 1 push plus 1 pop per cycle.

## Test plan
- Reset, then RX_MODE: push 0xA5, 0x3C, then pulse get_rx_data twice.
  - rx_data = 0xA5 the cycle after the first pop, 0x3C after the second.
  - Occupancy goes 1, 2, 1, 0; empty = 1 at the end.
- Fill/wrap in TX_MODE: push 64 bytes 0x00..0x3F, then one extra push.
  - full = 1, occupancy = 64, overflow_err pulses once.
  - Pop 64 bytes: tx_packet_data returns 0x00..0x3F in order.
  - A 65th pop pulses underflow_err with tx_packet_data held at 0x3F.
- Simultaneous push+pop:
  - When full: occupancy stays 64, the popped byte is the oldest, no overflow.
  - When empty: underflow_err = 1, push accepted, occupancy = 1.
- Direction switch with 5 bytes in RX_MODE: set d_mode=1.
  - One SWITCH cycle in which store_tx_data is ignored.
  - Occupancy = 0 afterwards, and store_tx_data is accepted from the following cycle.
- clear with 10 bytes stored and a same-cycle push:
  - Occupancy = 0, empty = 1, no error pulses, mode unchanged.
  - Wrong-direction strobes in either mode change nothing.
- rst pulsed mid-burst:
  - All outputs return to their reset values next cycle; state = RX_MODE.
